// File: rtl/vga_capture.sv
// VGA receive side: rebuilds the raster position from incoming HSYNC/VSYNC,
// checks frame timing and writes each active pixel to a frame buffer.
module vga_capture #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic        we,
    output logic [18:0] waddr,
    output logic [11:0] wdata,
    output logic        locked,
    output logic        frame_done,
    output logic        sync_err
);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        hs_r, vs_r, vpend_r, vpend_s;
    logic [10:0] hcnt_r, hcnt_s;
    logic [9:0]  vcnt_r, vcnt_s;
    logic [18:0] acnt_r, acnt_base_s;
    logic        hs_now_s, vs_now_s, hs_edge_s, vs_edge_s, frame_start_s;
    logic        line_bad_s, frame_bad_s, sat_s, err_s, in_h_s, in_v_s, cap_s;

    assign hs_now_s = (hsync_in == HS_POL[0]);
    assign vs_now_s = (vsync_in == VS_POL[0]);

    // Raster counters, timing checks and capture decision for the current sample
    always_comb begin
        hs_edge_s     = pix_ce & hs_now_s & ~hs_r;
        vs_edge_s     = pix_ce & vs_now_s & ~vs_r;
        frame_start_s = hs_edge_s & (vpend_r | vs_edge_s);

        if (frame_start_s) begin
            vpend_s = 1'b0;
        end else if (vs_edge_s) begin
            vpend_s = 1'b1;
        end else begin
            vpend_s = vpend_r;
        end

        if (hs_edge_s) begin
            hcnt_s = 11'd0;
        end else if (hcnt_r == 11'h7FF) begin
            hcnt_s = hcnt_r;
        end else begin
            hcnt_s = hcnt_r + 11'd1;
        end

        if (frame_start_s) begin
            vcnt_s = 10'd0;
        end else if (hs_edge_s) begin
            vcnt_s = vcnt_r + 10'd1;
        end else begin
            vcnt_s = vcnt_r;
        end

        // Checks use the counter values from before this sample's update
        line_bad_s  = hs_edge_s & (hcnt_r != 11'(H_TOTAL - 1));
        frame_bad_s = frame_start_s & (vcnt_r != 10'(V_TOTAL - 1));
        sat_s       = pix_ce & ~hs_edge_s & (hcnt_s == 11'h7FF);
        err_s       = (state_r != SEEK) & (line_bad_s | frame_bad_s | sat_s);

        in_h_s = (hcnt_s >= 11'(H_START)) && (hcnt_s < 11'(H_START + H_ACTIVE));
        in_v_s = (vcnt_s >= 10'(V_START)) && (vcnt_s < 10'(V_START + V_ACTIVE));
        cap_s  = pix_ce & (state_r == LOCKED) & ~err_s & in_h_s & in_v_s;

        acnt_base_s = frame_start_s ? 19'd0 : acnt_r;
    end

    // Lock state machine: one clean frame in MEASURE is needed before capture
    always_comb begin
        state_s = state_r;
        case (state_r)
            SEEK: begin
                if (frame_start_s) begin
                    state_s = MEASURE;
                end else begin
                    state_s = SEEK;
                end
            end
            MEASURE: begin
                if (err_s) begin
                    state_s = SEEK;
                end else if (frame_start_s) begin
                    state_s = LOCKED;
                end else begin
                    state_s = MEASURE;
                end
            end
            LOCKED: begin
                if (err_s) begin
                    state_s = SEEK;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: state_s = SEEK;
        endcase
    end

    // Sample, counter, state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_r       <= 1'b0;
            vs_r       <= 1'b0;
            vpend_r    <= 1'b0;
            hcnt_r     <= 11'd0;
            vcnt_r     <= 10'd0;
            acnt_r     <= 19'd0;
            state_r    <= SEEK;
            we         <= 1'b0;
            waddr      <= 19'd0;
            wdata      <= 12'd0;
            locked     <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            if (pix_ce) begin
                hs_r    <= hs_now_s;
                vs_r    <= vs_now_s;
                vpend_r <= vpend_s;
                hcnt_r  <= hcnt_s;
                vcnt_r  <= vcnt_s;
            end
            // Running write address, never a row*width product
            if (cap_s) begin
                waddr  <= acnt_base_s;
                wdata  <= rgb_in;
                acnt_r <= acnt_base_s + 19'd1;
            end else begin
                acnt_r <= acnt_base_s;
            end
            state_r    <= state_s;
            locked     <= (state_s == LOCKED);
            we         <= cap_s;
            frame_done <= cap_s & (acnt_base_s == 19'(H_ACTIVE * V_ACTIVE - 1));
            sync_err   <= err_s;
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced raster (20x12 total, 8x5 active),
// run on an active-low and an active-high sync instance side by side.
module tb_vga_capture;
    localparam int HT = 20, HS = 4, HA = 8, VT = 12, VS = 3, VA = 5;

    logic        clk = 1'b0, rst = 1'b1, pix_ce = 1'b0;
    logic        hs_act = 1'b0, vs_act = 1'b0, early_vs = 1'b0;
    logic [11:0] rgb_in = 12'd0;
    logic        we_o [2], locked_o [2], frame_done_o [2], sync_err_o [2], lk_prev [2];
    logic [18:0] waddr_o [2];
    logic [11:0] wdata_o [2];
    int n_vec = 0, n_err = 0, pix_n = 0, cur_h = 0, cur_v = 0, base_pix = 0;
    int wr_cnt [2], fd_cnt [2], se_cnt [2], addr_bad [2], data_bad [2], fd_bad [2], lk_bad [2];
    int lock_at [2], err_at [2], w0_at [2], d9 [2], b_wr [2], b_fd [2], b_se [2];

    always #5 clk = ~clk;

    vga_capture #(.H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA), .V_TOTAL(VT), .V_START(VS),
                  .V_ACTIVE(VA), .HS_POL(0), .VS_POL(0)) dut0 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync_in(~hs_act), .vsync_in(~vs_act),
        .rgb_in(rgb_in), .we(we_o[0]), .waddr(waddr_o[0]), .wdata(wdata_o[0]),
        .locked(locked_o[0]), .frame_done(frame_done_o[0]), .sync_err(sync_err_o[0]));

    vga_capture #(.H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA), .V_TOTAL(VT), .V_START(VS),
                  .V_ACTIVE(VA), .HS_POL(1), .VS_POL(1)) dut1 (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .hsync_in(hs_act), .vsync_in(vs_act),
        .rgb_in(rgb_in), .we(we_o[1]), .waddr(waddr_o[1]), .wdata(wdata_o[1]),
        .locked(locked_o[1]), .frame_done(frame_done_o[1]), .sync_err(sync_err_o[1]));

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: each write is checked against the pixel the bench just sent
    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d] = 0; fd_cnt[d] = 0; se_cnt[d] = 0; addr_bad[d] = 0; data_bad[d] = 0;
            fd_bad[d] = 0; lk_bad[d] = 0; lock_at[d] = -1; err_at[d] = -1; w0_at[d] = -1;
            d9[d] = -1; lk_prev[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (we_o[d]) begin
                    wr_cnt[d]++;
                    if (int'(waddr_o[d]) != (cur_v - VS) * HA + (cur_h - HS)) addr_bad[d]++;
                    if (wdata_o[d] != {4'(cur_h - HS), 4'(cur_v - VS), 4'hA}) data_bad[d]++;
                    if (waddr_o[d] == 19'd0) w0_at[d] = pix_n;
                    if (waddr_o[d] == 19'd9) d9[d] = int'(wdata_o[d]);
                end
                if (frame_done_o[d]) fd_cnt[d]++;
                if (frame_done_o[d] != (we_o[d] && waddr_o[d] == 19'(HA * VA - 1))) fd_bad[d]++;
                if (sync_err_o[d]) begin
                    se_cnt[d]++;
                    err_at[d] = pix_n;
                    if (locked_o[d]) lk_bad[d]++;
                end
                if (locked_o[d] && !lk_prev[d]) lock_at[d] = pix_n;
                lk_prev[d] = locked_o[d];
            end
        end
    end

    task automatic pix(input logic hsa, input logic vsa, input logic [11:0] rgb,
                       input int h, input int v);
        @(negedge clk);
        hs_act = hsa; vs_act = vsa; rgb_in = rgb; cur_h = h; cur_v = v; pix_ce = 1'b1;
        @(posedge clk);
        pix_n++;
        @(negedge clk);
        pix_ce = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rst_pulse_check();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("mid_rst_we[%0d]", d), int'(we_o[d]), 0);
            chk($sformatf("mid_rst_waddr[%0d]", d), int'(waddr_o[d]), 0);
            chk($sformatf("mid_rst_wdata[%0d]", d), int'(wdata_o[d]), 0);
            chk($sformatf("mid_rst_locked[%0d]", d), int'(locked_o[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic gen_frame(input int short_v, input int rst_v, input int rst_h);
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                logic act, vsa;
                logic [11:0] rgb;
                if (!(v == short_v && h == HT - 1)) begin
                    act = (h >= HS) && (h < HS + HA) && (v >= VS) && (v < VS + VA);
                    rgb = act ? {4'(h - HS), 4'(v - VS), 4'hA} : 12'd0;
                    vsa = (v == 0) || (early_vs && v == VT - 1 && h >= 10);
                    pix(h < 2, vsa, rgb, h, v);
                    if (v == rst_v && h == rst_h) rst_pulse_check();
                end
            end
        end
    endtask

    task automatic snap();
        base_pix = pix_n;
        for (int d = 0; d < 2; d++) begin
            b_wr[d] = wr_cnt[d]; b_fd[d] = fd_cnt[d]; b_se[d] = se_cnt[d];
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_we[%0d]", d), int'(we_o[d]), 0);
            chk($sformatf("rst_waddr[%0d]", d), int'(waddr_o[d]), 0);
            chk($sformatf("rst_wdata[%0d]", d), int'(wdata_o[d]), 0);
            chk($sformatf("rst_locked[%0d]", d), int'(locked_o[d]), 0);
            chk($sformatf("rst_fdone[%0d]", d), int'(frame_done_o[d]), 0);
            chk($sformatf("rst_serr[%0d]", d), int'(sync_err_o[d]), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Clean start: MEASURE in frame 1, LOCKED at frame-2 start, full capture
        snap();
        gen_frame(-1, -1, -1);
        gen_frame(-1, -1, -1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("a_lock_at[%0d]", d), lock_at[d] - base_pix, 241);
            chk($sformatf("a_w0_at[%0d]", d), w0_at[d] - base_pix, 305);
            chk($sformatf("a_writes[%0d]", d), wr_cnt[d] - b_wr[d], HA * VA);
            chk($sformatf("a_fdone[%0d]", d), fd_cnt[d] - b_fd[d], 1);
            chk($sformatf("a_serr[%0d]", d), se_cnt[d] - b_se[d], 0);
            chk($sformatf("a_data9[%0d]", d), d9[d], 12'h11A);
            chk($sformatf("a_locked[%0d]", d), int'(locked_o[d]), 1);
        end

        // One short line while locked, then relock two frame starts later
        snap();
        gen_frame(5, -1, -1);
        gen_frame(-1, -1, -1);
        gen_frame(-1, -1, -1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("b_serr[%0d]", d), se_cnt[d] - b_se[d], 1);
            chk($sformatf("b_err_at[%0d]", d), err_at[d] - base_pix, 120);
            chk($sformatf("b_lock_at[%0d]", d), lock_at[d] - base_pix, 480);
            chk($sformatf("b_writes[%0d]", d), wr_cnt[d] - b_wr[d], 24 + HA * VA);
            chk($sformatf("b_fdone[%0d]", d), fd_cnt[d] - b_fd[d], 1);
        end

        // Reset pulse mid-frame right after a write, then relock
        snap();
        gen_frame(-1, 4, 8);
        gen_frame(-1, -1, -1);
        gen_frame(-1, -1, -1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("c_lock_at[%0d]", d), lock_at[d] - base_pix, 481);
            chk($sformatf("c_writes[%0d]", d), wr_cnt[d] - b_wr[d], 13 + HA * VA);
            chk($sformatf("c_serr[%0d]", d), se_cnt[d] - b_se[d], 0);
            chk($sformatf("c_fdone[%0d]", d), fd_cnt[d] - b_fd[d], 1);
        end

        // Coincident vsync, then vsync 10 pixels into the previous last line
        snap();
        early_vs = 1'b1;
        gen_frame(-1, -1, -1);
        for (int d = 0; d < 2; d++)
            chk($sformatf("d_w0_coinc[%0d]", d), w0_at[d] - base_pix, 65);
        gen_frame(-1, -1, -1);
        early_vs = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d_w0_early[%0d]", d), w0_at[d] - base_pix, 305);
            chk($sformatf("d_writes[%0d]", d), wr_cnt[d] - b_wr[d], 2 * HA * VA);
            chk($sformatf("d_fdone[%0d]", d), fd_cnt[d] - b_fd[d], 2);
            chk($sformatf("d_serr[%0d]", d), se_cnt[d] - b_se[d], 0);
            chk($sformatf("d_locked[%0d]", d), int'(locked_o[d]), 1);
        end

        // Missing hsync while locked: hcnt saturates at 2047
        snap();
        for (int k = 1; k <= 2030; k++) pix(1'b0, 1'b0, 12'd0, HT - 1 + k, 99);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("e_serr[%0d]", d), se_cnt[d] - b_se[d], 1);
            chk($sformatf("e_err_at[%0d]", d), err_at[d] - base_pix, 2028);
            chk($sformatf("e_locked[%0d]", d), int'(locked_o[d]), 0);
            chk($sformatf("e_writes[%0d]", d), wr_cnt[d] - b_wr[d], 0);
            chk($sformatf("addr_map[%0d]", d), addr_bad[d], 0);
            chk($sformatf("wdata[%0d]", d), data_bad[d], 0);
            chk($sformatf("fdone_align[%0d]", d), fd_bad[d], 0);
            chk($sformatf("lock_drop[%0d]", d), lk_bad[d], 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
